ps2_receiver: RTL and testbench
===============================

# ps2_receiver

Deserialises the raw PS/2 keyboard bus (ps2_clk, ps2_data) into 8-bit scancodes. Each validated byte is presented on `scancode` with a single-cycle `ready` strobe. It sits directly upstream of the keyboard decoder and drives that block's `scancode`/`ready` inputs. It synchronises and deglitches the asynchronous bus, checks the 11-bit frame, and recovers from stalled or corrupted frames via an inter-bit timeout.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before the filtered ps2_clk level changes.
- `TIMEOUT_CYCLES`, default 100000: maximum clk cycles between falling edges inside a frame before the frame is aborted.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock from the keyboard, asynchronous, idles high.
- `ps2_data` input 1: raw PS/2 data from the keyboard, asynchronous, idles high.
- `scancode` output 8: last valid received byte; held until the next valid byte.
- `ready` output 1: one-cycle pulse; `scancode` is valid in the same cycle.
- `frame_err` output 1: one-cycle pulse on a parity, stop or timeout failure.

## Operation
- **Synchroniser:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser; both flops reset to 1.
- **Clock filter:**
  - Counter tracks how long the synchronised ps2_clk has differed from the filtered level `clk_f` (reset 1).
  - The counter clears whenever they are equal.
  - `clk_f` toggles on the cycle the counter reaches `FILTER_LEN`; the counter then clears.
  - `fall` = `clk_f` going 1→0 (single-cycle strobe). Rising edges are ignored.
- **Data sampling:** on each `fall`, the synchronised `ps2_data` value in that same cycle is the sampled bit.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with bit=0 (start bit), clear the 3-bit bit counter and go to DATA. On `fall` with bit=1, stay in IDLE with no error.
  - DATA: on `fall`, shift the bit into an 8-bit shift register, LSB first (bit 0 received first). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP.
  - STOP: on `fall`, always return to IDLE.
    - If the stop bit is 1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity), load `scancode` from the shift register and pulse `ready`.
    - Otherwise pulse `frame_err` and leave `scancode` unchanged.
- **Timeout:**
  - In DATA, PARITY or STOP, a watchdog counts clk cycles and clears on every `fall`.
  - On reaching `TIMEOUT_CYCLES`, go to IDLE and pulse `frame_err`; no `ready`.
  - The watchdog is held at 0 in IDLE.
- **Byte handling:** every byte, including prefix and break codes (E0, F0), is delivered as its own `ready` pulse. No interpretation is done here.

## Timing
- **Reset values:** `scancode` = 8'h00, `ready` = 0, `frame_err` = 0. State IDLE, `clk_f` = 1, all counters 0, shift register 0.
- **Reset mid-frame:** the partial frame is discarded. After release, reception resumes only at the next start bit.
- **Outputs:** `ready` and `frame_err` are registered and assert in the cycle after the `fall` of the stop bit (or after the timeout expiry). Each is high for exactly 1 cycle and never asserts simultaneously with the other.
- **Latency:** raw stop-bit falling edge → `ready` high is 2 + `FILTER_LEN` + 1 clk cycles, ±1 for synchroniser sampling phase.
- **Glitch rejection:** a ps2_clk low pulse shorter than `FILTER_LEN` cycles produces no `fall`.
- **Sampling point:** data is sampled `FILTER_LEN`+2 cycles after the raw clock edge. This is far inside the ≥30 µs PS/2 low phase at any clk ≥ 1 MHz with default `FILTER_LEN`.
- **Back-to-back frames:** frames separated by only the stop-bit high phase are received without loss. IDLE accepts the next start bit on the `fall` immediately following STOP.
- **Simultaneous events:** a `fall` arriving in the cycle the watchdog expires is dropped and the timeout wins. The FSM is then in IDLE, and the next start bit restarts reception.
- **Downstream:** no backpressure; the consumer must accept `ready` in its cycle.

## Test plan
- **Valid byte:** frame start 0, data 0x6B LSB-first, parity 0, stop 1 → one `ready` pulse, `scancode` = 8'h6B, `frame_err` stays 0.
- **Sequence:** E0 (parity 0), F0 (parity 1), 75 (parity 0) back-to-back → three `ready` pulses, `scancode` 8'hE0, 8'hF0, 8'h75 in order.
- **Frame errors:**
  - 0x29 sent with parity 1 → one `frame_err` pulse, no `ready`, `scancode` keeps its previous value.
  - Repeat with correct parity but stop = 0 → same response.
- **Glitch rejection:** ps2_clk low glitches of `FILTER_LEN`−1 cycles injected mid-frame, then a valid 0x72 frame → `scancode` = 8'h72, exactly one `ready`, no `frame_err`.
- **Timeout:** send start plus 4 data bits, then hold ps2_clk high for `TIMEOUT_CYCLES`+10 → `frame_err` pulse once. A following valid 0x74 frame → `ready`, `scancode` = 8'h74.
- **Reset mid-frame:** assert `rst` asynchronously (not clk-aligned) after 5 data bits → `scancode` = 00 and `ready`/`frame_err` = 0 immediately. The rest of the broken frame produces nothing (no start bit recognised). A following valid 0x6B frame → `ready`, `scancode` = 8'h6B.

Source files
------------

// File: rtl/ps2_receiver.sv
// ----------------------------------------------------------------------------
// ps2_receiver
//
// Turns the raw PS/2 keyboard bus into 8-bit scancodes. Both bus lines are
// synchronised. The PS/2 clock is deglitched by a run-length filter. Each
// 11-bit frame (start, 8 data LSB first, odd parity, stop) is checked. A
// watchdog aborts frames that stall between falling edges.
//
// Parameters
//   FILTER_LEN     : consecutive differing samples needed to flip clk_f
//   TIMEOUT_CYCLES : max clk cycles between falling edges inside a frame
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ps2_clk    in   raw PS/2 clock (async, idles high)
//   ps2_data   in   raw PS/2 data  (async, idles high)
//   scancode   out  last valid byte, held until the next valid byte
//   ready      out  one-cycle strobe, scancode valid in the same cycle
//   frame_err  out  one-cycle strobe on parity, stop or timeout failure
// ----------------------------------------------------------------------------
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       ready,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          clk_f_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;
  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [WW-1:0] wd_reg;
  logic [7:0]    scancode_reg;
  logic          ready_reg;
  logic          frame_err_reg;

  logic sample_bit;
  assign sample_bit = data_sync_reg[1];

  // Two-flop synchronisers; idle level is 1 so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // Run-length filter: clk_f only follows the synchronised clock after it
  // has disagreed for FILTER_LEN consecutive cycles. fall_reg strobes in the
  // first cycle clk_f is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f_reg    <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_sync_reg[1] == clk_f_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        clk_f_reg    <= ~clk_f_reg;
        filt_cnt_reg <= '0;
        fall_reg     <= clk_f_reg;  // only the 1->0 transition is an edge
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // Frame FSM, watchdog and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      wd_reg        <= '0;
      scancode_reg  <= 8'h00;
      ready_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      ready_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      if (state_reg != IDLE && wd_reg == WD_LAST) begin
        // Timeout has priority: a fall in this same cycle is dropped.
        state_reg     <= IDLE;
        wd_reg        <= '0;
        frame_err_reg <= 1'b1;
      end else begin
        if (state_reg == IDLE || fall_reg)
          wd_reg <= '0;
        else
          wd_reg <= wd_reg + 1'b1;

        if (fall_reg) begin
          case (state_reg)
            IDLE: begin
              if (!sample_bit) begin
                bit_cnt_reg <= '0;
                state_reg   <= DATA;
              end
            end
            DATA: begin
              shift_reg   <= {sample_bit, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == 3'd7)
                state_reg <= PARITY;
            end
            PARITY: begin
              parity_reg <= sample_bit;
              state_reg  <= STOP;
            end
            STOP: begin
              state_reg <= IDLE;
              if (sample_bit && ((^shift_reg) ^ parity_reg)) begin
                scancode_reg <= shift_reg;
                ready_reg    <= 1'b1;
              end else begin
                frame_err_reg <= 1'b1;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  assign scancode  = scancode_reg;
  assign ready     = ready_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       ready;
  logic       frame_err;

  ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scancode  (scancode),
    .ready     (ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    bit         glitch;
    bit         exp_err;
  } vec_t;

  ev_t        sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // One PS/2 bit: data set while clock high, high phase, low phase, release.
  task automatic send_bit(input bit b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(6);
      ps2_clk = 1'b0;
      wait_cyc(FL - 1);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 6 - (FL - 1));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit stop, input bit glitch);
    logic par;
    par = ~(^d) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    ps2_data = 1'b1;
  endtask

  // Scoreboard consumer: every ready/frame_err pulse must match the head.
  always @(negedge clk) begin
    if (!rst && (ready || frame_err)) begin
      ev_t e;
      $display("event ready=%0d frame_err=%0d scancode=%02h", ready, frame_err, scancode);
      check("no_simultaneous", {31'd0, ready & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
        if (!e.is_err) check("event_scancode", {24'd0, scancode}, {24'd0, e.code});
      end
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h75, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h29, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h72, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    check("reset_scancode", {24'd0, scancode}, 32'h00);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Table: frames sent back-to-back, checked at each stop-bit release.
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{vecs[i].exp_err, vecs[i].data});
      if (!vecs[i].exp_err) last_good = vecs[i].data;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop, vecs[i].glitch);
      check($sformatf("vec%0d_pending", i), sb.size(), 32'd0);
      check($sformatf("vec%0d_scancode", i), {24'd0, scancode}, {24'd0, last_good});
    end

    // Timeout: start + 4 data bits, then stall.
    sb.push_back('{1'b1, 8'h00});
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_cyc(TO + 10);
    check("timeout_pending", sb.size(), 32'd0);
    check("timeout_scancode", {24'd0, scancode}, {24'd0, last_good});
    sb.push_back('{1'b0, 8'h74});
    send_frame(8'h74, 1'b0, 1'b1, 1'b0);
    check("after_timeout_pending", sb.size(), 32'd0);
    check("after_timeout_scancode", {24'd0, scancode}, 32'h74);

    // Reset mid-frame: start + 5 data bits of 0xFF, async reset, then the rest.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    wait_cyc(5);
    #4 rst = 1'b1;
    #1;
    check("midrst_scancode", {24'd0, scancode}, 32'h00);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);  // parity of 0xFF
    send_bit(1'b1, 1'b0);  // stop
    wait_cyc(20);
    check("broken_frame_silent", sb.size(), 32'd0);
    check("broken_frame_scancode", {24'd0, scancode}, 32'h00);
    sb.push_back('{1'b0, 8'h6B});
    send_frame(8'h6B, 1'b0, 1'b1, 1'b0);
    wait_cyc(20);
    check("final_pending", sb.size(), 32'd0);
    check("final_scancode", {24'd0, scancode}, 32'h6B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
